// File: rtl/rst_release_seq.sv
// Staged reset-release sequencer: releases domain resets one at a time
// in index order, waits for each ack, then services software resets.
module rst_release_seq #(
  parameter int NUM_DOM     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sys_rst_ni,
  input  logic [NUM_DOM-1:0] sw_rst_req_i,
  input  logic [NUM_DOM-1:0] dom_ack_i,
  output logic [NUM_DOM-1:0] dom_rst_no,
  output logic               busy_o,
  output logic               seq_done_o,
  output logic [NUM_DOM-1:0] timeout_o
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_SW_HOLD,
    S_SW_WAIT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_DOM-1:0] r_dom;
  logic [NUM_DOM-1:0] r_to;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [NUM_DOM-1:0] w_dom_nxt;
  logic [NUM_DOM-1:0] w_to_nxt;
  logic [NUM_DOM-1:0] w_sel;
  logic               w_ack;
  logic [IDX_W-1:0]   w_low;

  assign w_sel = NUM_DOM'(1) << r_idx;
  assign w_ack = |(dom_ack_i & w_sel);

  // Lowest set software request index.
  always_comb begin
    w_low = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (sw_rst_req_i[i]) w_low = IDX_W'(i);
    end
  end

  // Next-state, counter, index and output-register updates.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_dom_nxt   = r_dom;
    w_to_nxt    = r_to;
    unique case (r_state)
      S_HOLD: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_RELEASE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE: begin
        w_dom_nxt   = r_dom | w_sel;
        w_state_nxt = S_WAIT_ACK;
        w_cnt_nxt   = '0;
      end
      S_WAIT_ACK, S_SW_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_ack || r_cnt == ACK_LAST) begin
          if (!w_ack) w_to_nxt = r_to | w_sel;
          w_cnt_nxt   = '0;
          w_state_nxt = (r_state == S_WAIT_ACK) ?
                        S_GAP : S_DONE;
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_RELEASE;
          end
        end
      end
      S_DONE: begin
        if (|sw_rst_req_i) begin
          w_idx_nxt   = w_low;
          w_dom_nxt   = r_dom & ~(NUM_DOM'(1) << w_low);
          w_cnt_nxt   = '0;
          w_state_nxt = S_SW_HOLD;
        end
      end
      S_SW_HOLD: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == HOLD_LAST) begin
          w_dom_nxt   = r_dom | w_sel;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SW_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
    // System reset abandons everything except timeout history.
    if (!sys_rst_ni) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_dom_nxt   = '0;
      w_to_nxt    = r_to;
    end
  end

  // State and output registers with synchronous block reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dom   <= '0;
      r_to    <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_dom   <= w_dom_nxt;
      r_to    <= w_to_nxt;
      r_busy  <= (w_state_nxt != S_DONE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign dom_rst_no = r_dom;
  assign timeout_o  = r_to;
  assign busy_o     = r_busy;
  assign seq_done_o = r_done;

endmodule

// File: tb/tb_rst_release_seq.sv
// Bench for rst_release_seq: procedural timeline model feeding a
// scoreboard queue, plus directed latency spot checks.
module tb_rst_release_seq;

  localparam int N = 4;
  localparam int H = 16;
  localparam int G = 8;
  localparam int A = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i;
  logic       sys_rst_ni;
  logic [3:0] sw_rst_req_i;
  logic [3:0] dom_ack_i;
  logic [3:0] dom_rst_no;
  logic       busy_o;
  logic       seq_done_o;
  logic [3:0] timeout_o;

  logic [0:0] req2;
  logic [0:0] ack2;
  logic [0:0] dom2;
  logic [0:0] to2;
  logic       busy2;
  logic       done2;

  rst_release_seq u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .sys_rst_ni  (sys_rst_ni),
    .sw_rst_req_i(sw_rst_req_i),
    .dom_ack_i   (dom_ack_i),
    .dom_rst_no  (dom_rst_no),
    .busy_o      (busy_o),
    .seq_done_o  (seq_done_o),
    .timeout_o   (timeout_o)
  );

  rst_release_seq #(
    .NUM_DOM   (1),
    .GAP_CYCLES(0)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .sys_rst_ni  (sys_rst_ni),
    .sw_rst_req_i(req2),
    .dom_ack_i   (ack2),
    .dom_rst_no  (dom2),
    .busy_o      (busy2),
    .seq_done_o  (done2),
    .timeout_o   (to2)
  );

  typedef struct packed {
    logic [3:0] dom;
    logic [3:0] to;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];

  logic [3:0] e_dom;
  logic [3:0] e_to;
  logic       e_busy;
  logic       e_done;
  logic       s_rst;
  logic       s_sys;
  logic [3:0] s_req;
  logic [3:0] s_ack;

  int n_vec = 0;
  int n_bad = 0;

  task automatic push();
    exp_t x;
    x.dom  = e_dom;
    x.to   = e_to;
    x.busy = e_busy;
    x.done = e_done;
    q.push_back(x);
  endtask

  // One clock edge: sample inputs, apply any reset effect.
  task automatic tick(output bit ab);
    @(posedge clk);
    s_rst = rst_i;
    s_sys = sys_rst_ni;
    s_req = sw_rst_req_i;
    s_ack = dom_ack_i;
    ab = 1'b0;
    if (s_rst) begin
      e_to = '0;
      ab   = 1'b1;
    end else if (!s_sys) begin
      ab = 1'b1;
    end
    if (ab) begin
      e_dom  = '0;
      e_busy = 1'b1;
      e_done = 1'b0;
    end
  endtask

  task automatic wait_ack(int d, bit sw, output bit ab);
    for (int k = 0; k < A; k++) begin
      tick(ab);
      if (!ab && (s_ack[d] || k == A - 1)) begin
        if (!s_ack[d]) e_to[d] = 1'b1;
        if (sw) begin
          e_busy = 1'b0;
          e_done = 1'b1;
        end
        push();
        return;
      end
      push();
      if (ab) return;
    end
  endtask

  // Timeline of one sequence; returns whenever a reset hits.
  task automatic run_seq();
    bit ab;
    int dd;
    for (int h = 0; h < H; h++) begin
      tick(ab);
      push();
      if (ab) return;
    end
    for (int d = 0; d < N; d++) begin
      tick(ab);
      if (!ab) e_dom[d] = 1'b1;
      push();
      if (ab) return;
      wait_ack(d, 1'b0, ab);
      if (ab) return;
      for (int g = 0; g < ((G > 0) ? G : 1); g++) begin
        tick(ab);
        if (!ab && d == N - 1 && g == ((G > 0) ? G : 1) - 1) begin
          e_busy = 1'b0;
          e_done = 1'b1;
        end
        push();
        if (ab) return;
      end
    end
    forever begin
      tick(ab);
      dd = -1;
      if (!ab && s_req != 0) begin
        for (int i = N - 1; i >= 0; i--) if (s_req[i]) dd = i;
        e_dom[dd] = 1'b0;
        e_busy = 1'b1;
        e_done = 1'b0;
      end
      push();
      if (ab) return;
      if (dd >= 0) begin
        for (int h = 0; h < H; h++) begin
          tick(ab);
          if (!ab && h == H - 1) e_dom[dd] = 1'b1;
          push();
          if (ab) return;
        end
        wait_ack(dd, 1'b1, ab);
        if (ab) return;
      end
    end
  endtask

  initial begin
    forever run_seq();
  end

  // Monitor: one expected record per clock edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {dom_rst_no, timeout_o, busy_o, seq_done_o};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got dom=%b to=%b busy=%b done=%b want dom=%b to=%b busy=%b done=%b",
                 $time, a.dom, a.to, a.busy, a.done,
                 e.dom, e.to, e.busy, e.done);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  int f0, f1, fm, f2, fd;
  logic [3:0] stuck;

  initial begin
    rst_i = 1'b1;
    sys_rst_ni = 1'b0;
    sw_rst_req_i = '0;
    dom_ack_i = 4'hF;
    req2 = '0;
    ack2 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dom", int'(dom_rst_no), 0);
    check("reset_busy_done", int'({busy_o, seq_done_o}), 2);
    rst_i = 1'b0;
    sys_rst_ni = 1'b1;
    f0 = -1; f1 = -1; fm = -1; f2 = -1; fd = -1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (f0 < 0 && dom_rst_no[0]) f0 = k;
      if (f1 < 0 && dom_rst_no[1]) f1 = k;
      if (fm < 0 && seq_done_o) fm = k;
      if (f2 < 0 && dom2[0]) f2 = k;
      if (fd < 0 && done2) fd = k;
      sw_rst_req_i = (k == 20) ? 4'hF : 4'h0;
    end
    check("lat_dom0", f0, H + 1);
    check("lat_dom1", f1, H + 1 + 2 + G);
    check("lat_done", fm, H + 1 + 3 * (2 + G) + 1 + G);
    check("n1_lat_dom", f2, H + 1);
    check("n1_lat_done", fd, H + 3);

    @(negedge clk) sw_rst_req_i = 4'b0101;
    @(negedge clk) sw_rst_req_i = 4'b0000;
    repeat (30) @(negedge clk);

    sys_rst_ni = 1'b0;
    dom_ack_i = 4'b1101;
    repeat (2) @(negedge clk);
    sys_rst_ni = 1'b1;
    repeat (330) @(negedge clk);
    check("timeout_dom1", int'(timeout_o), 2);
    check("timeout_all_released", int'(dom_rst_no), 15);
    dom_ack_i = 4'hF;

    sys_rst_ni = 1'b0;
    dom_ack_i = 4'b1011;
    @(negedge clk) sys_rst_ni = 1'b1;
    repeat (40) @(negedge clk);
    sys_rst_ni = 1'b0;
    @(negedge clk);
    check("abort_dom", int'(dom_rst_no), 0);
    check("abort_busy", int'(busy_o), 1);
    sys_rst_ni = 1'b1;
    dom_ack_i = 4'hF;
    repeat (70) @(negedge clk);
    check("restart_done", int'(seq_done_o), 1);
    check("timeout_kept", int'(timeout_o), 2);

    stuck = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 400 == 0)
        stuck = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      rst_i = ($urandom % 1500 == 0);
      sys_rst_ni = ($urandom % 300 != 0);
      dom_ack_i = 4'($urandom | $urandom | $urandom) & ~stuck;
      sw_rst_req_i = ($urandom % 15 == 0) ? 4'($urandom) : 4'h0;
    end
    rst_i = 1'b0;
    sys_rst_ni = 1'b1;
    sw_rst_req_i = '0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
